// File: rtl/rv_pkg.sv
// Shared RV32I core constants used by the fetch stage and its neighbours.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO with synchronous flush; the payload width is generic so
// the same block can buffer {instr, pc} pairs anywhere in the pipeline.
module fetch_queue #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o,
    output logic         empty_o,
    output logic         full_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // NOTE: registers are only ever written with non-blocking assignments so
    // every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // NOTE: storage has no reset; count_q alone says which entries hold data.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction-fetch stage: owns the PC, issues credit-limited word
// fetches, tags responses with their PC and hands them to decode.
module instr_fetch #(
    parameter int                XLEN     = rv_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_PC = rv_pkg::RESET_PC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_gnt,
    input  logic                    imem_rvalid,
    input  logic [rv_pkg::ILEN-1:0] imem_rdata,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic                    id_valid,
    input  logic                    id_ready,
    output logic [rv_pkg::ILEN-1:0] id_instr,
    output logic [XLEN-1:0]         id_pc
);

    import rv_pkg::*;

    localparam int QW = ILEN + XLEN;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]      outst_q, outst_d;
    logic [1:0]      drop_q, drop_d;
    logic            req_en_q;
    logic [XLEN-1:0] tag_q [2];
    logic            tag_wr_q, tag_rd_q;

    logic            accept, rsp, push, pop;
    logic [QW-1:0]   q_head;
    logic [1:0]      q_count;
    logic            q_empty, q_full;
    logic            unused_ok;

    assign accept = imem_req & imem_gnt;
    // A response with nothing outstanding is spurious and leaves all state alone.
    assign rsp    = imem_rvalid & (outst_q != 2'd0);
    assign push   = rsp & (drop_q == 2'd0) & ~redirect_valid;
    assign pop    = id_valid & id_ready;

    // Words in flight plus words queued never exceed the queue depth.
    assign imem_req  = req_en_q & ~redirect_valid
                     & (({1'b0, outst_q} + {1'b0, q_count}) < 3'd2);
    assign imem_addr = fetch_pc_q;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        outst_d    = outst_q + {1'b0, accept} - {1'b0, rsp};

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            drop_d     = outst_d;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (rsp && drop_q != 2'd0) drop_d = drop_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            outst_q    <= 2'd0;
            drop_q     <= 2'd0;
            req_en_q   <= 1'b0;
            tag_wr_q   <= 1'b0;
            tag_rd_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            req_en_q   <= 1'b1;
            if (accept) tag_wr_q <= ~tag_wr_q;
            if (rsp)    tag_rd_q <= ~tag_rd_q;
        end
    end

    // Dropped responses still retire their tag so the pair stays in order.
    always_ff @(posedge clk) begin
        if (accept) tag_q[tag_wr_q] <= fetch_pc_q;
    end

    fetch_queue #(
        .W(QW)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_data_i({imem_rdata, tag_q[tag_rd_q]}),
        .pop_i      (pop),
        .flush_i    (redirect_valid),
        .head_o     (q_head),
        .count_o    (q_count),
        .empty_o    (q_empty),
        .full_o     (q_full)
    );

    assign id_valid = ~q_empty;
    assign id_instr = q_empty ? NOP_INSTR : q_head[QW-1:XLEN];
    assign id_pc    = q_empty ? RESET_PC  : q_head[XLEN-1:0];

    assign unused_ok = ^{redirect_pc[1:0], q_full};

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a memory model answers fetches, and a
// monitor checks the decode stream against the program-order PC sequence.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = rv_pkg::RESET_PC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout expected DUT event", name);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h7FF0_0203;
        if (a == 32'h4) return 32'h03A1_2123;
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
    endfunction

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pend[$];
    int    cyc = 0;
    int    gnt_pct = 100;
    int    lat_max = 0;
    int    rdy_pct = 100;
    bit    mem_hold = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!mem_hold) begin
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(pend[0].addr);
                    void'(pend.pop_front());
                end else begin
                    imem_rvalid = 1'b0;
                    imem_rdata  = $urandom;
                end
                imem_gnt = ($urandom_range(99) < gnt_pct);
            end
            id_ready = ($urandom_range(99) < rdy_pct);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && imem_req && imem_gnt)
                pend.push_back('{addr: imem_addr, due: cyc + 1 + int'($urandom_range(lat_max))});
        end
    end

    // ---------------- scoreboard and monitor ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] sb_pc;
    logic [31:0] exp_fetch;
    int          n_acc = 0;
    int          n_deliv = 0;

    task automatic sb_fill();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: sb_pc, instr: mem_word(sb_pc)});
            sb_pc += 32'd4;
        end
    endtask

    task automatic sb_restart(input logic [31:0] target);
        exp_q.delete();
        sb_pc = target;
        sb_fill();
    endtask

    initial begin
        bit          hold_chk = 1'b0;
        bit          novalid_chk = 1'b0;
        logic [31:0] hold_addr = 32'h0;
        exp_t        e;
        sb_restart(RST_PC);
        exp_fetch = RST_PC;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_restart(RST_PC);
                exp_fetch   = RST_PC;
                hold_chk    = 1'b0;
                novalid_chk = 1'b0;
            end else begin
                if (novalid_chk) check("id_valid after redirect", id_valid, 1'b0);
                novalid_chk = 1'b0;
                if (hold_chk && !redirect_valid) begin
                    check("req held until grant", imem_req, 1'b1);
                    check("addr held until grant", imem_addr, hold_addr);
                end
                if (id_valid && id_ready) begin
                    e = exp_q.pop_front();
                    check("id_pc", id_pc, e.pc);
                    check("id_instr", id_instr, e.instr);
                    n_deliv++;
                    sb_fill();
                end
                if (imem_req && imem_gnt) begin
                    check("fetch addr", imem_addr, exp_fetch);
                    exp_fetch += 32'd4;
                    n_acc++;
                end
                if (redirect_valid) begin
                    check("imem_req in redirect cycle", imem_req, 1'b0);
                    sb_restart(redirect_pc & ~32'h3);
                    exp_fetch   = redirect_pc & ~32'h3;
                    novalid_chk = 1'b1;
                end
                hold_chk  = imem_req && !imem_gnt && !redirect_valid;
                hold_addr = imem_addr;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        pend.delete();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_id_valid(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (id_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) timeout(name);
    endtask

    task automatic wait_pend2(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (pend.size() == 2) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) timeout(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int d0;
        int a0;
        int hits;

        #1 rst_n = 1'b0;
        #2;
        check("reset imem_req", imem_req, 1'b0);
        check("reset imem_addr", imem_addr, RST_PC);
        check("reset id_valid", id_valid, 1'b0);
        check("reset id_instr", id_instr, rv_pkg::NOP_INSTR);
        check("reset id_pc", id_pc, RST_PC);

        // 1: free-running fetch from reset
        step();
        step();
        rst_n = 1'b1;
        step();
        check("t1 req after reset", imem_req, 1'b1);
        wait_id_valid("t1 first instr", ok);
        check("t1 first id_pc", id_pc, 32'h0);
        check("t1 first id_instr", id_instr, 32'h7FF0_0203);
        step();
        check("t1 second id_valid", id_valid, 1'b1);
        check("t1 second id_pc", id_pc, 32'h4);
        check("t1 second id_instr", id_instr, 32'h03A1_2123);
        repeat (6) step();
        // The credit of two covers in-flight and queued words, so with
        // one-cycle memory latency the stream settles at two words per three cycles.
        d0 = n_deliv;
        repeat (30) step();
        check("t1 sustained delivery", (n_deliv - d0) >= 18, 1'b1);

        // 2: decode stalled
        rdy_pct = 0;
        do_reset();
        a0 = n_acc;
        repeat (6) step();
        check("t2 accepts while stalled <= 2", (n_acc - a0) <= 2, 1'b1);
        check("t2 imem_req dropped", imem_req, 1'b0);
        check("t2 id_valid held", id_valid, 1'b1);
        rdy_pct = 100;
        step();
        check("t2 first id_pc after release", id_pc, 32'h0);
        step();
        check("t2 second id_pc after release", id_pc, 32'h4);
        repeat (10) step();

        // 3: redirect with two fetches in flight
        lat_max = 4;
        wait_pend2("t3 two outstanding", ok);
        redirect(32'h0000_0101);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (ok) check("t3 next request addr", imem_addr, 32'h0000_0100);
        else timeout("t3 next request");
        wait_id_valid("t3 first instr", ok);
        check("t3 first id_pc", id_pc, 32'h0000_0100);
        repeat (10) step();

        // 4: redirect coinciding with a response and a grant
        lat_max = 0;
        repeat (8) step();
        hits = 0;
        for (int i = 0; i < 10 && hits == 0; i++) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h0000_0200 + 32'h40 * i;
            if (imem_rvalid && imem_gnt) begin
                hits++;
                #1;
                check("t4 imem_req in redirect cycle", imem_req, 1'b0);
            end
            step();
            redirect_valid = 1'b0;
            repeat (4) step();
        end
        check("t4 redirect met rvalid and gnt", hits > 0, 1'b1);
        repeat (10) step();

        // 5: wrap-around
        redirect(32'hFFFF_FFFC);
        wait_id_valid("t5 first instr", ok);
        check("t5 id_pc at top", id_pc, 32'hFFFF_FFFC);
        step();
        wait_id_valid("t5 wrapped instr", ok);
        check("t5 id_pc after wrap", id_pc, 32'h0);
        repeat (6) step();

        // 6: asynchronous reset with fetches in flight
        lat_max = 3;
        wait_pend2("t6 two outstanding", ok);
        rst_n = 1'b0;
        #1;
        check("t6 id_valid in reset", id_valid, 1'b0);
        check("t6 imem_addr in reset", imem_addr, RST_PC);
        check("t6 imem_req in reset", imem_req, 1'b0);
        mem_hold    = 1'b1;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        pend.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rdata  = 32'hCAFE_F00D;
        step();
        imem_rvalid = 1'b0;
        step();
        check("t6 stale rvalid ignored", id_valid, 1'b0);
        check("t6 restart addr", imem_addr, RST_PC);
        mem_hold = 1'b0;
        wait_id_valid("t6 first instr", ok);
        check("t6 first id_pc", id_pc, RST_PC);

        // random traffic with occasional and back-to-back redirects
        gnt_pct = 70;
        lat_max = 3;
        rdy_pct = 60;
        for (int i = 0; i < 500; i++) begin
            step();
            if (redirect_valid) begin
                if ($urandom_range(3) == 0) redirect_pc = $urandom;
                else redirect_valid = 1'b0;
            end else if ($urandom_range(24) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end
        end
        step();
        redirect_valid = 1'b0;
        repeat (30) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
